// File: rtl/raycast_raygen.sv
// raycast_raygen: orthographic ray buffer generator writing 7-word records over a WB burst master
// Define RAYC_RAYGEN_CULL_EN to flag records whose slab interval is empty or behind the camera.
module raycast_raygen #(
  parameter int DW  = 32,
  parameter int XYW = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [31:0]     buf_adr_i,
  input  logic [XYW-1:0]  width_i,
  input  logic [XYW-1:0]  height_i,
  input  logic [2:0]      dir_mask_i,
  input  logic [6*DW-1:0] t_base_i,
  input  logic [6*DW-1:0] t_du_i,
  input  logic [6*DW-1:0] t_dv_i,
  output logic [31:0]     m_wb_adr_o,
  output logic [31:0]     m_wb_dat_o,
  output logic [3:0]      m_wb_sel_o,
  output logic            m_wb_we_o,
  output logic            m_wb_cyc_o,
  output logic            m_wb_stb_o,
  input  logic            m_wb_ack_i,
  output logic [2:0]      m_wb_cti_o,
  output logic [1:0]      m_wb_bte_o,
  output logic            busy_o,
  output logic [31:0]     ray_count_o,
  output logic            finished_o
);
  typedef enum logic [2:0] {IDLE, SETUP, WRITE, NEXT, FINISH} state_t;
  state_t state, state_nx;
  logic [XYW-1:0] w, h, u, v;
  logic [2:0] mask, widx;
  logic [6*DW-1:0] cur, row, du, dv, cur_du, row_dv;
  logic cull;
  for (genvar i = 0; i < 6; i++) begin : g_lane
    assign cur_du[i*DW +: DW] = cur[i*DW +: DW] + du[i*DW +: DW];
    assign row_dv[i*DW +: DW] = row[i*DW +: DW] + dv[i*DW +: DW];
  end
`ifdef RAYC_RAYGEN_CULL_EN
  logic signed [DW-1:0] l [6];
  logic signed [DW-1:0] e01, t_entry, x01, t_exit;
  for (genvar i = 0; i < 6; i++) begin : g_sl
    assign l[i] = cur[i*DW +: DW];
  end
  assign e01     = l[0] > l[1] ? l[0] : l[1];
  assign t_entry = e01 > l[2] ? e01 : l[2];
  assign x01     = l[3] < l[4] ? l[3] : l[4];
  assign t_exit  = x01 < l[5] ? x01 : l[5];
  assign cull    = (t_entry >= t_exit) || (t_exit < 0);
`else
  assign cull = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = !start_i ? IDLE : (width_i == '0 || height_i == '0) ? FINISH : SETUP;
      SETUP:   state_nx = WRITE;
      WRITE:   state_nx = (m_wb_ack_i && widx == 3'd6) ? NEXT : WRITE;
      NEXT:    state_nx = (u < w - 1'b1 || v < h - 1'b1) ? SETUP : FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      m_wb_cyc_o  <= 1'b0;
      m_wb_stb_o  <= 1'b0;
      m_wb_we_o   <= 1'b0;
      m_wb_cti_o  <= 3'b000;
      m_wb_adr_o  <= '0;
      m_wb_dat_o  <= '0;
      m_wb_sel_o  <= 4'hF;
      m_wb_bte_o  <= 2'b00;
      busy_o      <= 1'b0;
      finished_o  <= 1'b0;
      ray_count_o <= '0;
      w           <= '0;
      h           <= '0;
      u           <= '0;
      v           <= '0;
      mask        <= '0;
      widx        <= '0;
      cur         <= '0;
      row         <= '0;
      du          <= '0;
      dv          <= '0;
    end else begin
      state      <= state_nx;
      busy_o     <= state_nx != IDLE;
      finished_o <= state == FINISH;
      unique case (state)
        IDLE: if (start_i) begin
          m_wb_adr_o  <= buf_adr_i;
          w           <= width_i;
          h           <= height_i;
          mask        <= dir_mask_i;
          cur         <= t_base_i;
          row         <= t_base_i;
          du          <= t_du_i;
          dv          <= t_dv_i;
          u           <= '0;
          v           <= '0;
          ray_count_o <= 32'(width_i) * 32'(height_i);
        end
        SETUP: begin
          m_wb_dat_o <= {cull, 28'b0, mask};
          widx       <= '0;
          m_wb_cyc_o <= 1'b1;
          m_wb_stb_o <= 1'b1;
          m_wb_we_o  <= 1'b1;
          m_wb_cti_o <= 3'b010;
        end
        WRITE: if (m_wb_ack_i) begin
          m_wb_adr_o <= m_wb_adr_o + 32'd4;
          widx       <= widx + 3'd1;
          if (widx == 3'd6) begin
            m_wb_cyc_o <= 1'b0;
            m_wb_stb_o <= 1'b0;
            m_wb_we_o  <= 1'b0;
            m_wb_cti_o <= 3'b000;
          end else begin
            m_wb_dat_o <= cur[widx*DW +: DW];
            m_wb_cti_o <= widx == 3'd5 ? 3'b111 : 3'b010;
          end
        end
        NEXT: if (u < w - 1'b1) begin
          u   <= u + 1'b1;
          cur <= cur_du;
        end else if (v < h - 1'b1) begin
          u   <= '0;
          v   <= v + 1'b1;
          row <= row_dv;
          cur <= row_dv;
        end
        default: ;
      endcase
    end
  end
endmodule
